// File: rtl/mini16_loader_pkg.sv
// Shared definitions for the UART program loader: FSM states, frame magic, word helpers.
// Optional build macro: LOADER_CHECKSUM_EN adds the trailing XOR checksum byte and CSUM state.
package mini16_loader_pkg;

  localparam logic [7:0] MAGIC = 8'hA5;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StCsum, StDone, StError
  } loader_state_e;
  // State entered once the last payload word (or a zero length) has been seen
  localparam loader_state_e StPayloadEnd = StCsum;
`else
  typedef enum logic [2:0] {
    StIdle, StLenLo, StLenHi, StData, StDone, StError
  } loader_state_e;
  localparam loader_state_e StPayloadEnd = StDone;
`endif

  function automatic int unsigned bytes_per_word(input int unsigned inst_width);
    return inst_width / 8;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling timer and LSB-first shifter.
module uart_rx_byte #(
  parameter int unsigned UART_CLK_HZ  = 510000000,
  parameter int unsigned UART_SCLK_HZ = 115200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_rxd,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err
);

  localparam int unsigned DIV  = UART_CLK_HZ / UART_SCLK_HZ;
  localparam int unsigned HALF = DIV / 2;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e   state_q;
  logic        rxd_meta_q, rxd_sync_q, rxd_prev_q;
  logic [31:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        half_tick, bit_tick;

  // Bit-timer terminal counts: start-bit centre and full bit period
  always_comb begin
    half_tick = (cnt_q == 32'(HALF - 1));
    bit_tick  = (cnt_q == 32'(DIV - 1));
  end

  // Synchronise the asynchronous line; the extra stage gives falling-edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= uart_rxd;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  // Receive state machine: start qualification, 8 data samples, stop check
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RxIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      cnt_q        <= cnt_q + 32'd1;
      unique case (state_q)
        RxIdle: begin
          cnt_q <= '0;
          if (rxd_prev_q && !rxd_sync_q) state_q <= RxStart;
        end
        RxStart: begin
          if (half_tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            // Line back high at the centre means it was only a glitch
            state_q <= rxd_sync_q ? RxIdle : RxData;
          end
        end
        RxData: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            shift_q <= {rxd_sync_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RxStop;
          end
        end
        RxStop: begin
          if (bit_tick) begin
            cnt_q   <= '0;
            state_q <= RxIdle;
            if (rxd_sync_q) begin
              rx_valid <= 1'b1;
              rx_data  <= shift_q;
            end else begin
              rx_frame_err <= 1'b1;
            end
          end
        end
        default: state_q <= RxIdle;
      endcase
    end
  end

endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: receives a framed program image over UART and writes it into instruction
// memory while holding the CPU in reset. Frame: A5, LEN_LO, LEN_HI, LEN little-endian words.
// Optional build macro: LOADER_CHECKSUM_EN appends an XOR checksum byte over length and data.
module uart_program_loader
  import mini16_loader_pkg::*;
#(
  parameter int unsigned UART_CLK_HZ    = 510000000,
  parameter int unsigned UART_SCLK_HZ   = 115200,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned INST_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 51000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rxd,
  output logic                  cpu_reset,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [INST_WIDTH-1:0] mem_wdata,
  output logic                  loading,
  output logic                  error,
  output logic                  done
);

  localparam int unsigned BPW   = bytes_per_word(INST_WIDTH);
  localparam int unsigned IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [7:0]            rx_data;
  logic                  rx_valid, rx_frame_err;
  loader_state_e         state_q;
  logic [7:0]            len_lo_q;
  logic [15:0]           words_left_q;
  logic [IDX_W-1:0]      byte_idx_q;
  logic [INST_WIDTH-1:0] word_q;
  logic [31:0]           tmo_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            csum_q;
`endif

  logic                  in_frame, go_error, is_magic, last_byte;
  logic [15:0]           len_full;
  logic [INST_WIDTH+7:0] word_cat;
  logic [INST_WIDTH-1:0] word_nxt;

  uart_rx_byte #(
    .UART_CLK_HZ  (UART_CLK_HZ),
    .UART_SCLK_HZ (UART_SCLK_HZ)
  ) u_rx (
    .clk          (clk),
    .reset        (reset),
    .uart_rxd     (uart_rxd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

  // Frame-level conditions and little-endian word assembly (new byte enters at the top)
  always_comb begin
    in_frame = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
`ifdef LOADER_CHECKSUM_EN
    in_frame = in_frame || (state_q == StCsum);
`endif
    go_error  = ((state_q != StIdle) && rx_frame_err) ||
                (in_frame && !rx_valid && (tmo_q == 32'(TIMEOUT_CYCLES - 1)));
    is_magic  = rx_valid && (rx_data == MAGIC) &&
                ((state_q == StIdle) || (state_q == StError));
    last_byte = (byte_idx_q == IDX_W'(BPW - 1));
    len_full  = {rx_data, len_lo_q};
    word_cat  = {rx_data, word_q};
    word_nxt  = word_cat[INST_WIDTH+7:8];
  end

  // Loader FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      cpu_reset    <= 1'b1;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      loading      <= 1'b0;
      error        <= 1'b0;
      done         <= 1'b0;
      len_lo_q     <= '0;
      words_left_q <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      tmo_q        <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      // Address advances in the cycle after the write strobe, wrapping naturally
      if (mem_we) mem_addr <= mem_addr + ADDR_WIDTH'(1);
      if (!in_frame || rx_valid) tmo_q <= '0;
      else                       tmo_q <= tmo_q + 32'd1;

      if (go_error) begin
        state_q   <= StError;
        loading   <= 1'b0;
        error     <= 1'b1;
        cpu_reset <= 1'b1;
      end else if (is_magic) begin
        state_q    <= StLenLo;
        loading    <= 1'b1;
        cpu_reset  <= 1'b1;
        error      <= 1'b0;
        mem_addr   <= '0;
        byte_idx_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end else begin
        unique case (state_q)
          StIdle: cpu_reset <= 1'b0;
          StLenLo: begin
            if (rx_valid) begin
              len_lo_q <= rx_data;
              state_q  <= StLenHi;
`ifdef LOADER_CHECKSUM_EN
              csum_q   <= csum_q ^ rx_data;
`endif
            end
          end
          StLenHi: begin
            if (rx_valid) begin
              words_left_q <= len_full;
              state_q      <= (len_full == 16'd0) ? StPayloadEnd : StData;
`ifdef LOADER_CHECKSUM_EN
              csum_q       <= csum_q ^ rx_data;
`endif
            end
          end
          StData: begin
            if (rx_valid) begin
              word_q <= word_nxt;
`ifdef LOADER_CHECKSUM_EN
              csum_q <= csum_q ^ rx_data;
`endif
              if (last_byte) begin
                byte_idx_q   <= '0;
                mem_we       <= 1'b1;
                mem_wdata    <= word_nxt;
                words_left_q <= words_left_q - 16'd1;
                if (words_left_q == 16'd1) state_q <= StPayloadEnd;
              end else begin
                byte_idx_q <= byte_idx_q + IDX_W'(1);
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          StCsum: begin
            if (rx_valid) begin
              if (rx_data == csum_q) begin
                state_q <= StDone;
              end else begin
                // Words already written stay in memory; the CPU stays held
                state_q   <= StError;
                loading   <= 1'b0;
                error     <= 1'b1;
                cpu_reset <= 1'b1;
              end
            end
          end
`endif
          StDone: begin
            done    <= 1'b1;
            loading <= 1'b0;
            state_q <= StIdle;
          end
          StError: begin
            loading   <= 1'b0;
            error     <= 1'b1;
            cpu_reset <= 1'b1;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed bench for uart_program_loader with a 10-clock UART bit period.
// With LOADER_CHECKSUM_EN defined, full frames carry the XOR checksum byte.
module tb_uart_program_loader;

  localparam int unsigned DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rxd = 1'b1;
  logic        cpu_reset, mem_we, loading, error, done;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  uart_program_loader #(
    .UART_CLK_HZ    (1152000),
    .UART_SCLK_HZ   (115200),
    .ADDR_WIDTH     (10),
    .INST_WIDTH     (32),
    .TIMEOUT_CYCLES (500)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .uart_rxd  (uart_rxd),
    .cpu_reset (cpu_reset),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .loading   (loading),
    .error     (error),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Write / done monitor, sampled on the falling edge
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          done_cnt = 0;
  logic        done_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(32'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
    if (done) begin
      done_cnt++;
      check("loading_low_at_done", 32'(loading), 32'd0);
      check("cpu_held_at_done", 32'(cpu_reset), 32'd1);
    end
    if (done_prev) check("cpu_released_after_done", 32'(cpu_reset), 32'd0);
    done_prev = done;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    uart_rxd = 1'b0;
    idle(DIV);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      idle(DIV);
    end
    uart_rxd = stop_bit;
    idle(DIV);
    uart_rxd = 1'b1;
    idle(2 * DIV);
  endtask

  logic [7:0] tx[$];

  task automatic send_raw();
    foreach (tx[i]) send_byte(tx[i], 1'b1);
  endtask

  task automatic send_frame();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] x;
    x = 8'h00;
    for (int i = 1; i < tx.size(); i++) x ^= tx[i];
    tx.push_back(x);
`endif
    send_raw();
  endtask

  task automatic check_write(input int idx, input logic [31:0] addr, input logic [31:0] data);
    if (wr_data.size() > idx) begin
      check($sformatf("wr%0d_addr", idx), wr_addr[idx], addr);
      check($sformatf("wr%0d_data", idx), wr_data[idx], data);
    end else begin
      check($sformatf("wr%0d_present", idx), 32'(wr_data.size()), 32'(idx + 1));
    end
  endtask

  initial begin
    // Reset values
    idle(3);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_loading", 32'(loading), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    idle(1);
    check("cpu_release_after_reset", 32'(cpu_reset), 32'd0);

    // Two-word load
    tx = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame();
    idle(30);
    check("a_wr_count", 32'(wr_data.size()), 32'd2);
    check_write(0, 32'd0, 32'h44332211);
    check_write(1, 32'd1, 32'h88776655);
    check("a_done_cnt", 32'(done_cnt), 32'd1);
    check("a_error", 32'(error), 32'd0);
    check("a_cpu_reset", 32'(cpu_reset), 32'd0);
    check("a_loading", 32'(loading), 32'd0);

    // Zero-length load
    tx = '{8'hA5, 8'h00, 8'h00};
    send_frame();
    idle(30);
    check("b_wr_count", 32'(wr_data.size()), 32'd2);
    check("b_done_cnt", 32'(done_cnt), 32'd2);
    check("b_cpu_reset", 32'(cpu_reset), 32'd0);

    // Stall mid-word until timeout
    tx = '{8'hA5};
    send_raw();
    check("t_loading_mid", 32'(loading), 32'd1);
    check("t_cpu_held_mid", 32'(cpu_reset), 32'd1);
    tx = '{8'h01, 8'h00, 8'h11, 8'h22};
    send_raw();
    idle(700);
    check("t_error", 32'(error), 32'd1);
    check("t_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t_loading", 32'(loading), 32'd0);
    check("t_wr_count", 32'(wr_data.size()), 32'd2);
    tx = '{8'hA5, 8'h01, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame();
    idle(30);
    check("r_error", 32'(error), 32'd0);
    check("r_cpu_reset", 32'(cpu_reset), 32'd0);
    check("r_wr_count", 32'(wr_data.size()), 32'd3);
    check_write(2, 32'd0, 32'hEFBEADDE);
    check("r_done_cnt", 32'(done_cnt), 32'd3);

    // Framing error inside DATA
    tx = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_raw();
    send_byte(8'h22, 1'b0);
    idle(10);
    check("f_error", 32'(error), 32'd1);
    check("f_cpu_reset", 32'(cpu_reset), 32'd1);
    check("f_loading", 32'(loading), 32'd0);
    check("f_wr_count", 32'(wr_data.size()), 32'd3);
    tx = '{8'hA5, 8'h00, 8'h00};
    send_frame();
    idle(30);
    check("f_clear_error", 32'(error), 32'd0);
    check("f_clear_done_cnt", 32'(done_cnt), 32'd4);
    // Bad-stop magic while idle is dropped
    send_byte(8'hA5, 1'b0);
    idle(10);
    check("fi_error", 32'(error), 32'd0);
    check("fi_cpu_reset", 32'(cpu_reset), 32'd0);
    check("fi_loading", 32'(loading), 32'd0);

    // Reset after two bytes of a word
    tx = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    send_raw();
    check("m_loading_before", 32'(loading), 32'd1);
    reset = 1'b1;
    idle(1);
    check("m_cpu_reset", 32'(cpu_reset), 32'd1);
    check("m_mem_we", 32'(mem_we), 32'd0);
    check("m_mem_addr", 32'(mem_addr), 32'd0);
    check("m_mem_wdata", mem_wdata, 32'd0);
    check("m_loading", 32'(loading), 32'd0);
    check("m_error", 32'(error), 32'd0);
    reset = 1'b0;
    idle(1);
    check("m_cpu_release", 32'(cpu_reset), 32'd0);
    tx = '{8'h33, 8'h44};
    send_raw();
    idle(30);
    check("m_wr_count", 32'(wr_data.size()), 32'd3);
    check("m_loading_after", 32'(loading), 32'd0);
    check("m_done_cnt", 32'(done_cnt), 32'd4);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 01^00^01^02^03^04 = 05
    tx = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send_raw();
    idle(30);
    check("c_done_cnt", 32'(done_cnt), 32'd5);
    check("c_error", 32'(error), 32'd0);
    check_write(3, 32'd0, 32'h04030201);
    // Bad checksum: word still written, load ends in error
    tx = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06};
    send_raw();
    idle(30);
    check("cb_error", 32'(error), 32'd1);
    check("cb_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cb_done_cnt", 32'(done_cnt), 32'd5);
    check("cb_wr_count", 32'(wr_data.size()), 32'd5);
    check_write(4, 32'd0, 32'h04030201);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
